// File: rtl/coll_pkg.sv
// Shared definitions for the collision scheduler: FSM state encoding and
// helpers for pair counting, index widths and the flat pair index.
package coll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_EVAL,
    ST_WAIT,
    ST_WB,
    ST_NEXT
  } state_e;

  // Number of unordered pairs among n balls.
  function automatic int num_pairs(input int n);
    return (n * (n - 1)) / 2;
  endfunction

  // Width of an index able to address n items (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Flat index of pair (a,b), a<b, in the order the sweep visits them.
  function automatic int pair_idx(input int a, input int b, input int n);
    return (a * (2 * n - a - 1)) / 2 + (b - a - 1);
  endfunction

endpackage

// File: rtl/pair_iter.sv
// Pair iterator: walks (sel_a, sel_b) over all unordered pairs a<b.
// start_i reloads (0,1); advance_i steps to the next pair; last_o flags
// the final pair (N_BALLS-2, N_BALLS-1).
module pair_iter
  import coll_pkg::*;
#(
  parameter int N_BALLS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       advance_i,
  output logic [idx_w(N_BALLS)-1:0]  sel_a_o,
  output logic [idx_w(N_BALLS)-1:0]  sel_b_o,
  output logic                       last_o
);

  localparam int IW = idx_w(N_BALLS);
  localparam logic [IW-1:0] LAST_A = IW'(N_BALLS - 2);
  localparam logic [IW-1:0] LAST_B = IW'(N_BALLS - 1);

  logic [IW-1:0] sel_a_q, sel_a_d;
  logic [IW-1:0] sel_b_q, sel_b_d;

  // Next pair: bump sel_b, or wrap to the next row once sel_b hits the top ball.
  always_comb begin
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (start_i) begin
      sel_a_d = '0;
      sel_b_d = IW'(1);
    end else if (advance_i) begin
      if (sel_b_q == LAST_B) begin
        sel_a_d = sel_a_q + IW'(1);
        sel_b_d = sel_a_q + IW'(2);
      end else begin
        sel_b_d = sel_b_q + IW'(1);
      end
    end
  end

  // Pair index registers; reset parks on the first pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_a_q <= '0;
      sel_b_q <= IW'(1);
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign sel_a_o = sel_a_q;
  assign sel_b_o = sel_b_q;
  assign last_o  = (sel_a_q == LAST_A) && (sel_b_q == LAST_B);

endmodule

// File: rtl/collision_scheduler.sv
// Collision scheduler: on each frame_tick sweeps every ball pair through the
// shared collision datapath, waits CALC_LAT cycles after a qualifying hit and
// pulses wb_en to commit the new velocity/direction.
// Optional feature macro: COLL_PAIR_STICKY_EN keeps one contact bit per pair
// so only new contacts (hit now, no hit last sweep) are written back.
module collision_scheduler
  import coll_pkg::*;
#(
  parameter int N_BALLS  = 3,
  parameter int CALC_LAT = 2,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic                        coll_hit,
  output logic [$clog2(N_BALLS)-1:0]  sel_a,
  output logic [$clog2(N_BALLS)-1:0]  sel_b,
  output logic                        wb_en,
  output logic                        busy,
  output logic                        sweep_done,
  output logic                        overrun,
  output logic [CNT_W-1:0]            hit_cnt
);

  localparam int IW = idx_w(N_BALLS);
  localparam int CW = $clog2(CALC_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CW-1:0]    wait_q, wait_d;
  logic             wb_en_q, wb_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  logic             iter_start, iter_advance, iter_last;
  logic [IW-1:0]    sel_a_w, sel_b_w;
  logic             qualify;

  pair_iter #(
    .N_BALLS (N_BALLS)
  ) u_pair_iter (
    .clk       (clk),
    .rst       (rst),
    .start_i   (iter_start),
    .advance_i (iter_advance),
    .sel_a_o   (sel_a_w),
    .sel_b_o   (sel_b_w),
    .last_o    (iter_last)
  );

`ifdef COLL_PAIR_STICKY_EN
  localparam int NP = num_pairs(N_BALLS);
  localparam int PW = (NP > 1) ? $clog2(NP) : 1;

  logic [NP-1:0] contact_q, contact_d;
  logic [PW-1:0] pidx;

  // Contact bit of the current pair: qualify only on a fresh contact, and
  // record this frame's hit flag for the next sweep.
  always_comb begin
    pidx      = PW'(pair_idx(int'(sel_a_w), int'(sel_b_w), N_BALLS));
    qualify   = coll_hit && !contact_q[pidx];
    contact_d = contact_q;
    if (state_q == ST_EVAL) begin
      contact_d[pidx] = coll_hit;
    end
  end

  // Contact bit storage, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      contact_q <= '0;
    end else begin
      contact_q <= contact_d;
    end
  end
`else
  assign qualify = coll_hit;
`endif

  // Sweep FSM next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    wb_en_d      = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    hit_cnt_d    = hit_cnt_q;
    iter_start   = 1'b0;
    iter_advance = 1'b0;

    if (frame_tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d    = ST_SEL;
          iter_start = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_SEL: begin
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (qualify) begin
          wait_d  = CW'(CALC_LAT);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - CW'(1);
        if (wait_q == CW'(1)) begin
          // Counter reaches zero on entry to WB: raise the commit pulse and count it.
          state_d = ST_WB;
          wb_en_d = 1'b1;
          if (hit_cnt_q != CNT_MAX) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WB: begin
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (iter_last) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          iter_advance = 1'b1;
          state_d      = ST_SEL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      wb_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      wb_en_q   <= wb_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign sel_a      = sel_a_w;
  assign sel_b      = sel_b_w;
  assign wb_en      = wb_en_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;
  assign overrun    = overrun_q;
  assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed testbench for collision_scheduler (N_BALLS=3, CALC_LAT=2).
// A second instance with CNT_W=2 shares all inputs to observe saturation.
// Cycle numbering per sweep: cycle 0 carries frame_tick, cycle 1 is the first SEL.
module tb_collision_scheduler;

`ifdef COLL_PAIR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       frame_tick;
  logic       coll_hit;
  logic [2:0] hit_mask;

  logic [1:0] sel_a, sel_b;
  logic       wb_en, busy, sweep_done, overrun;
  logic [7:0] hit_cnt;

  logic [1:0] s2_sel_a, s2_sel_b;
  logic       s2_wb_en, s2_busy, s2_sweep_done, s2_overrun;
  logic [1:0] s2_hit_cnt;

  int checks = 0;
  int errors = 0;

  int wb_n, wb_a, wb_b, wb_c, done_cyc, busy_start, done_busy, cnt;

  collision_scheduler #(.N_BALLS(3), .CALC_LAT(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .coll_hit(coll_hit),
    .sel_a(sel_a), .sel_b(sel_b), .wb_en(wb_en), .busy(busy),
    .sweep_done(sweep_done), .overrun(overrun), .hit_cnt(hit_cnt)
  );

  collision_scheduler #(.N_BALLS(3), .CALC_LAT(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .coll_hit(coll_hit),
    .sel_a(s2_sel_a), .sel_b(s2_sel_b), .wb_en(s2_wb_en), .busy(s2_busy),
    .sweep_done(s2_sweep_done), .overrun(s2_overrun), .hit_cnt(s2_hit_cnt)
  );

  // Datapath stand-in: hit flag per pair, (0,1)->bit0, (0,2)->bit1, (1,2)->bit2.
  always_comb begin
    int pidx;
    coll_hit = 1'b0;
    pidx = int'(sel_a) + int'(sel_b) - 1;
    if (pidx >= 0 && pidx < 3) coll_hit = hit_mask[pidx];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sweep: optional extra tick at ovr_cyc, optional reset at rst_cyc (returns right after it).
  task automatic run_sweep(input logic [2:0] mask, input int ovr_cyc, input int rst_cyc);
    hit_mask = mask;
    wb_n = 0; wb_a = -1; wb_b = -1; wb_c = -1;
    done_cyc = -1; busy_start = -1; done_busy = -1;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (cyc == ovr_cyc) frame_tick = 1'b1;
      if (cyc == rst_cyc) rst = 1'b1;
      @(negedge clk);
      if (cyc == 1) busy_start = int'(busy);
      if (wb_en) begin
        wb_n++; wb_a = int'(sel_a); wb_b = int'(sel_b); wb_c = cyc;
      end
      if (sweep_done) begin
        done_cyc = cyc; done_busy = int'(busy);
        break;
      end
      @(posedge clk); #1;
      frame_tick = 1'b0;
      if (cyc == rst_cyc) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; hit_mask = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sel_a", int'(sel_a), 0);
    chk("rst_sel_b", int'(sel_b), 1);
    chk("rst_wb_en", int'(wb_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(sweep_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_hit_cnt", int'(hit_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1) no hits: 3 pairs x 3 cycles, done at cycle 10
    run_sweep(3'b000, 0, 0);
    chk("t1_busy_start", busy_start, 1);
    chk("t1_done_cyc", done_cyc, 10);
    chk("t1_done_busy", done_busy, 0);
    chk("t1_wb_n", wb_n, 0);
    chk("t1_end_sel_a", int'(sel_a), 1);
    chk("t1_end_sel_b", int'(sel_b), 2);
    @(negedge clk);
    chk("t1_done_pulse", int'(sweep_done), 0);

    // 2) hit only on (0,2): EVAL at 5, wb at 8, done at 13
    run_sweep(3'b010, 0, 0);
    chk("t2_done_cyc", done_cyc, 13);
    chk("t2_wb_n", wb_n, 1);
    chk("t2_wb_a", wb_a, 0);
    chk("t2_wb_b", wb_b, 2);
    chk("t2_wb_cyc", wb_c, 8);
    chk("t2_hit_cnt", int'(hit_cnt), 1);

    // 3/4) (0,1) hit for two sweeps, none, then hit again
    run_sweep(3'b001, 0, 0);
    chk("t3_s1_wb_n", wb_n, 1);
    chk("t3_s1_wb_cyc", wb_c, 5);
    chk("t3_s1_done", done_cyc, 13);
    run_sweep(3'b001, 0, 0);
    chk("t3_s2_wb_n", wb_n, STICKY ? 0 : 1);
    chk("t3_s2_done", done_cyc, STICKY ? 10 : 13);
    run_sweep(3'b000, 0, 0);
    chk("t3_s3_wb_n", wb_n, 0);
    run_sweep(3'b001, 0, 0);
    chk("t3_s4_wb_n", wb_n, 1);
    chk("t3_hit_cnt", int'(hit_cnt), STICKY ? 3 : 4);

    // 5) second tick mid-sweep: ignored, overrun sticks
    chk("t5_ovr_before", int'(overrun), 0);
    run_sweep(3'b000, 5, 0);
    chk("t5_done_cyc", done_cyc, 10);
    chk("t5_overrun", int'(overrun), 1);
    @(negedge clk);
    chk("t5_overrun_hold", int'(overrun), 1);
    chk("t5_idle_busy", int'(busy), 0);

    // 6) reset during the second WAIT cycle of pair (0,1)
    run_sweep(3'b001, 0, 4);
    @(negedge clk);
    chk("t6_busy", int'(busy), 0);
    chk("t6_wb_n", wb_n, 0);
    chk("t6_hit_cnt", int'(hit_cnt), 0);
    chk("t6_overrun", int'(overrun), 0);
    chk("t6_sel_b", int'(sel_b), 1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (wb_en || sweep_done) cnt++;
    end
    chk("t6_no_pulses", cnt, 0);

    // Saturation: 3 hits, none, 2 hits -> 5 total; CNT_W=2 holds at 3
    run_sweep(3'b111, 0, 0);
    chk("sat_s1_done", done_cyc, 19);
    chk("sat_s1_cnt8", int'(hit_cnt), 3);
    chk("sat_s1_cnt2", int'(s2_hit_cnt), 3);
    run_sweep(3'b000, 0, 0);
    run_sweep(3'b011, 0, 0);
    chk("sat_s3_done", done_cyc, 16);
    chk("sat_cnt8", int'(hit_cnt), 5);
    chk("sat_cnt2", int'(s2_hit_cnt), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
